// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter
//   Two-channel write-side arbiter between the per-camera write FIFOs (FWFT,
//   clk domain) and the AXI write master. Grants bursts round-robin when a
//   FIFO holds at least one full burst, keeps a per-channel DDR burst address
//   with frame restart and wrap-around, and muxes the granted FIFO onto the
//   master's write-data input.
//
//   Optional feature macro: WR_PINGPANG_EN
//     When defined, each channel alternates between two frame banks
//     (bank 1 = bank 0 + PP_OFFSET) while the pingpang input is high, and
//     wr_bank_x reports the last completed bank. When undefined, the bank
//     base is always wr_beg_addr_x, wr_bank_x is 0 and pingpang is unused.
//
//   Ports
//     clk, rst_n                   clock, asynchronous active-low reset
//     pingpang                     runtime ping-pong enable
//     wr_beg_addr_x, wr_end_addr_x channel start / exclusive wrap address
//     wr_burst_len                 AXI length code (beats = len + 1)
//     wr_load_x                    frame-start pulse
//     fifo_cnt_x, fifo_dout_x      FIFO fill level and FWFT data
//     fifo_rd_en_x                 FIFO read strobe
//     axi_wr_ready/start/addr/len  burst request handshake to the master
//     axi_wr_data                  muxed write data
//     axi_writing, axi_wr_done     beat handshake and burst-complete pulse
//     wr_bank_x                    last fully written bank per channel
module axi_wr_arbiter #(
  parameter int unsigned AXI_WIDTH = 256,
  parameter int unsigned CNT_W     = 10,
  parameter logic [28:0] PP_OFFSET = 29'h0080_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pingpang,
  input  logic [28:0]          wr_beg_addr_1,
  input  logic [28:0]          wr_beg_addr_2,
  input  logic [28:0]          wr_end_addr_1,
  input  logic [28:0]          wr_end_addr_2,
  input  logic [7:0]           wr_burst_len,
  input  logic                 wr_load_1,
  input  logic                 wr_load_2,
  input  logic [CNT_W-1:0]     fifo_cnt_1,
  input  logic [CNT_W-1:0]     fifo_cnt_2,
  input  logic [AXI_WIDTH-1:0] fifo_dout_1,
  input  logic [AXI_WIDTH-1:0] fifo_dout_2,
  output logic                 fifo_rd_en_1,
  output logic                 fifo_rd_en_2,
  input  logic                 axi_wr_ready,
  output logic                 axi_wr_start,
  output logic [28:0]          axi_wr_addr,
  output logic [7:0]           axi_wr_len,
  output logic [AXI_WIDTH-1:0] axi_wr_data,
  input  logic                 axi_writing,
  input  logic                 axi_wr_done,
  output logic                 wr_bank_1,
  output logic                 wr_bank_2
);

  localparam int unsigned BYTES = AXI_WIDTH / 8;
  localparam int unsigned CMP_W = (CNT_W > 9) ? CNT_W : 9;

  typedef enum logic [1:0] {IDLE, START, BURST} state_t;

  state_t      state;
  logic        sel;        // granted channel: 0 = channel 1, 1 = channel 2
  logic        prio;       // preferred channel when both are eligible
  logic        init_done;
  logic [28:0] cur_addr [2];
  logic [1:0]  bank;
  logic [1:0]  pend;
  logic [1:0]  wr_bank_r;

  logic [28:0] beg_addr [2];
  logic [28:0] end_addr [2];
  logic [28:0] cur_base [2];
  logic [28:0] load_base [2];
  logic [28:0] next_addr [2];
  logic [28:0] gnt_addr [2];
  logic [1:0]  load, elig, granted, done_hit, bank_nxt;
  logic [CMP_W-1:0] need;
  logic [28:0] burst_bytes;
  logic [28:0] bank_off;
  logic        pp_on;
  logic        gnt_ch;

`ifdef WR_PINGPANG_EN
  assign pp_on    = pingpang;
  assign bank_off = PP_OFFSET;
`else
  logic unused_pp;
  assign pp_on     = 1'b0;
  assign bank_off  = '0;
  assign unused_pp = pingpang ^ (|PP_OFFSET);
`endif

  always_comb begin
    beg_addr[0] = wr_beg_addr_1;
    beg_addr[1] = wr_beg_addr_2;
    end_addr[0] = wr_end_addr_1;
    end_addr[1] = wr_end_addr_2;
    load        = {wr_load_2, wr_load_1};
    need        = CMP_W'(wr_burst_len) + CMP_W'(1);
    elig[0]     = CMP_W'(fifo_cnt_1) >= need;
    elig[1]     = CMP_W'(fifo_cnt_2) >= need;
    gnt_ch      = elig[1] && (!elig[0] || prio);
    burst_bytes = (29'(axi_wr_len) + 29'd1) * 29'(BYTES);
    for (int unsigned i = 0; i < 2; i++) begin
      bank_nxt[i]  = pp_on & ~bank[i];
      cur_base[i]  = beg_addr[i] + (bank[i] ? bank_off : '0);
      load_base[i] = beg_addr[i] + (bank_nxt[i] ? bank_off : '0);
      next_addr[i] = cur_addr[i] + burst_bytes;
      granted[i]   = (state != IDLE) && (sel == 1'(i));
      done_hit[i]  = (state == BURST) && axi_wr_done && (sel == 1'(i));
      // A frame start arriving on the grant cycle must already steer this burst.
      gnt_addr[i]  = load[i] ? load_base[i] : cur_addr[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sel          <= 1'b0;
      prio         <= 1'b0;
      init_done    <= 1'b0;
      bank         <= '0;
      pend         <= '0;
      wr_bank_r    <= '0;
      axi_wr_start <= 1'b0;
      axi_wr_addr  <= '0;
      axi_wr_len   <= '0;
      for (int unsigned i = 0; i < 2; i++) cur_addr[i] <= '0;
    end else begin
      axi_wr_start <= 1'b0;
      init_done    <= 1'b1;

      // Per-channel address: a frame start during the channel's own burst is
      // deferred to burst completion, where it overrides increment and wrap.
      for (int unsigned i = 0; i < 2; i++) begin
        if (!init_done) begin
          cur_addr[i] <= beg_addr[i];
        end else if (done_hit[i]) begin
          pend[i] <= 1'b0;
          if (pend[i] || load[i]) begin
            cur_addr[i] <= load_base[i];
            bank[i]     <= bank_nxt[i];
            if (pp_on) wr_bank_r[i] <= bank[i];
          end else if (next_addr[i] >= end_addr[i]) begin
            cur_addr[i] <= cur_base[i];
          end else begin
            cur_addr[i] <= next_addr[i];
          end
        end else if (load[i]) begin
          if (granted[i]) begin
            pend[i] <= 1'b1;
          end else begin
            cur_addr[i] <= load_base[i];
            bank[i]     <= bank_nxt[i];
            if (pp_on) wr_bank_r[i] <= bank[i];
          end
        end
      end

      case (state)
        IDLE: begin
          if (init_done && (elig != 2'b00)) begin
            sel         <= gnt_ch;
            axi_wr_addr <= gnt_addr[gnt_ch];
            axi_wr_len  <= wr_burst_len;
            state       <= START;
          end
        end
        START: begin
          if (axi_wr_ready) begin
            axi_wr_start <= 1'b1;
            state        <= BURST;
          end
        end
        BURST: begin
          if (axi_wr_done) begin
            prio  <= ~sel;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fifo_rd_en_1 = (state == BURST) && !sel && axi_writing;
  assign fifo_rd_en_2 = (state == BURST) &&  sel && axi_writing;
  assign axi_wr_data  = sel ? fifo_dout_2 : fifo_dout_1;
  assign wr_bank_1    = wr_bank_r[0];
  assign wr_bank_2    = wr_bank_r[1];

endmodule

// File: tb/tb_axi_wr_arbiter.sv
`timescale 1ns/1ps
module tb_axi_wr_arbiter;

  localparam int AXI_WIDTH = 256;
  localparam int CNT_W     = 10;
  localparam int BEATS     = 16;

  logic                 clk;
  logic                 rst_n;
  logic                 pingpang;
  logic [28:0]          wr_beg_addr_1, wr_beg_addr_2;
  logic [28:0]          wr_end_addr_1, wr_end_addr_2;
  logic [7:0]           wr_burst_len;
  logic                 wr_load_1, wr_load_2;
  logic [CNT_W-1:0]     fifo_cnt_1, fifo_cnt_2;
  logic [AXI_WIDTH-1:0] fifo_dout_1, fifo_dout_2;
  logic                 fifo_rd_en_1, fifo_rd_en_2;
  logic                 axi_wr_ready;
  logic                 axi_wr_start;
  logic [28:0]          axi_wr_addr;
  logic [7:0]           axi_wr_len;
  logic [AXI_WIDTH-1:0] axi_wr_data;
  logic                 axi_writing;
  logic                 axi_wr_done;
  logic                 wr_bank_1, wr_bank_2;

  axi_wr_arbiter #(
    .AXI_WIDTH (AXI_WIDTH),
    .CNT_W     (CNT_W),
    .PP_OFFSET (29'h0080_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pingpang      (pingpang),
    .wr_beg_addr_1 (wr_beg_addr_1),
    .wr_beg_addr_2 (wr_beg_addr_2),
    .wr_end_addr_1 (wr_end_addr_1),
    .wr_end_addr_2 (wr_end_addr_2),
    .wr_burst_len  (wr_burst_len),
    .wr_load_1     (wr_load_1),
    .wr_load_2     (wr_load_2),
    .fifo_cnt_1    (fifo_cnt_1),
    .fifo_cnt_2    (fifo_cnt_2),
    .fifo_dout_1   (fifo_dout_1),
    .fifo_dout_2   (fifo_dout_2),
    .fifo_rd_en_1  (fifo_rd_en_1),
    .fifo_rd_en_2  (fifo_rd_en_2),
    .axi_wr_ready  (axi_wr_ready),
    .axi_wr_start  (axi_wr_start),
    .axi_wr_addr   (axi_wr_addr),
    .axi_wr_len    (axi_wr_len),
    .axi_wr_data   (axi_wr_data),
    .axi_writing   (axi_writing),
    .axi_wr_done   (axi_wr_done),
    .wr_bank_1     (wr_bank_1),
    .wr_bank_2     (wr_bank_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [AXI_WIDTH-1:0] d1, d2;

  typedef struct {
    logic [CNT_W-1:0] c1;
    logic [CNT_W-1:0] c2;
    logic [28:0]      end1;
    int               ch;
    logic [28:0]      addr;
    bit               ld;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bench-side write master: waits for a start, plays BEATS beats with two
  // stall cycles, optionally pulses wr_load_1 mid-burst, then pulses done.
  task automatic run_burst(input int exp_ch, input logic [28:0] exp_addr,
                           input bit ld_mid, input string tag);
    int n;
    int c1;
    int c2;
    logic [AXI_WIDTH-1:0] exp_d;
    n = 0;
    c1 = 0;
    c2 = 0;
    exp_d = (exp_ch == 1) ? d1 : d2;
    while (axi_wr_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " start_seen"}, 64'(axi_wr_start), 64'd1);
    if (axi_wr_start !== 1'b1) return;
    chk({tag, " addr"}, 64'(axi_wr_addr), 64'(exp_addr));
    chk({tag, " len"}, 64'(axi_wr_len), 64'd15);
    axi_wr_ready = 1'b0;
    for (int b = 0; b < BEATS + 2; b++) begin
      axi_writing = (b != 5) && (b != 9);
      wr_load_1   = ld_mid && (b == 3);
      #1;
      c1 += int'(fifo_rd_en_1);
      c2 += int'(fifo_rd_en_2);
      if (b == 0) chk({tag, " data"}, 64'(axi_wr_data == exp_d), 64'd1);
      if (b == 1) chk({tag, " start_pulse"}, 64'(axi_wr_start), 64'd0);
      @(negedge clk);
    end
    axi_writing = 1'b0;
    wr_load_1   = 1'b0;
    axi_wr_done = 1'b1;
    @(negedge clk);
    axi_wr_done  = 1'b0;
    axi_wr_ready = 1'b1;
    chk({tag, " rd_en_1 count"}, 64'(c1), 64'((exp_ch == 1) ? BEATS : 0));
    chk({tag, " rd_en_2 count"}, 64'(c2), 64'((exp_ch == 2) ? BEATS : 0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic [28:0] pp_addr;
    logic        pp_bank;
`ifdef WR_PINGPANG_EN
    pp_addr = 29'h0080_0000;
    pp_bank = 1'b1;
`else
    pp_addr = 29'h0;
    pp_bank = 1'b0;
`endif

    d1 = {8{32'hA1A1_5A5A}};
    d2 = {8{32'hB2B2_C3C3}};

    //         c1     c2     end1        ch  addr            ld
    vt[0]  = '{10'd16, 10'd0,  29'h1000, 1, 29'h0000_0000, 1'b0};
    vt[1]  = '{10'd0,  10'd16, 29'h1000, 2, 29'h0100_0000, 1'b0};
    vt[2]  = '{10'd16, 10'd0,  29'h1000, 1, 29'h0000_0200, 1'b0};
    vt[3]  = '{10'd0,  10'd16, 29'h1000, 2, 29'h0100_0200, 1'b0};
    vt[4]  = '{10'd16, 10'd16, 29'h1000, 1, 29'h0000_0400, 1'b0};
    vt[5]  = '{10'd16, 10'd16, 29'h1000, 2, 29'h0100_0400, 1'b0};
    vt[6]  = '{10'd16, 10'd16, 29'h1000, 1, 29'h0000_0600, 1'b1};
    vt[7]  = '{10'd16, 10'd16, 29'h1000, 2, 29'h0100_0600, 1'b0};
    vt[8]  = '{10'd16, 10'd16, 29'h1000, 1, 29'h0000_0000, 1'b0};
    vt[9]  = '{10'd16, 10'd16, 29'h1000, 2, 29'h0100_0800, 1'b0};
    vt[10] = '{10'd16, 10'd0,  29'h0400, 1, 29'h0000_0200, 1'b0};
    vt[11] = '{10'd16, 10'd0,  29'h0400, 1, 29'h0000_0000, 1'b0};
    vt[12] = '{10'd16, 10'd0,  29'h0400, 1, 29'h0000_0200, 1'b0};
    vt[13] = '{10'd15, 10'd16, 29'h0400, 2, 29'h0100_0A00, 1'b0};
    vt[14] = '{10'd16, 10'd15, 29'h0400, 1, 29'h0000_0000, 1'b0};

    rst_n         = 1'b0;
    pingpang      = 1'b0;
    wr_beg_addr_1 = 29'h0;
    wr_end_addr_1 = 29'h1000;
    wr_beg_addr_2 = 29'h0100_0000;
    wr_end_addr_2 = 29'h0100_1000;
    wr_burst_len  = 8'd15;
    wr_load_1     = 1'b0;
    wr_load_2     = 1'b0;
    fifo_cnt_1    = '0;
    fifo_cnt_2    = '0;
    fifo_dout_1   = d1;
    fifo_dout_2   = d2;
    axi_wr_ready  = 1'b1;
    axi_writing   = 1'b0;
    axi_wr_done   = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset start", 64'(axi_wr_start), 64'd0);
    chk("reset addr", 64'(axi_wr_addr), 64'd0);
    chk("reset len", 64'(axi_wr_len), 64'd0);
    chk("reset rd_en", 64'({fifo_rd_en_1, fifo_rd_en_2}), 64'd0);
    chk("reset bank", 64'({wr_bank_1, wr_bank_2}), 64'd0);
    rst_n = 1'b1;

    // No grant without a full burst in either FIFO, then start latency
    repeat (3) @(negedge clk);
    chk("idle no start", 64'(axi_wr_start), 64'd0);
    fifo_cnt_1 = 10'd16;
    @(negedge clk);
    chk("start latency n", 64'(axi_wr_start), 64'd0);
    @(negedge clk);
    chk("start latency n+1", 64'(axi_wr_start), 64'd1);

    for (int i = 0; i < 15; i++) begin
      fifo_cnt_1    = vt[i].c1;
      fifo_cnt_2    = vt[i].c2;
      wr_end_addr_1 = vt[i].end1;
      run_burst(vt[i].ch, vt[i].addr, vt[i].ld, $sformatf("row%0d", i));
    end

    // Asynchronous reset in the middle of a burst
    wr_beg_addr_1 = 29'h3000;
    wr_end_addr_1 = 29'h4000;
    fifo_cnt_1    = 10'd16;
    fifo_cnt_2    = '0;
    n = 0;
    while (axi_wr_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("pre-reset start_seen", 64'(axi_wr_start), 64'd1);
    axi_wr_ready = 1'b0;
    axi_writing  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre-reset rd_en_1", 64'(fifo_rd_en_1), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid-burst reset rd_en_1", 64'(fifo_rd_en_1), 64'd0);
    chk("mid-burst reset start", 64'(axi_wr_start), 64'd0);
    chk("mid-burst reset addr", 64'(axi_wr_addr), 64'd0);
    chk("mid-burst reset len", 64'(axi_wr_len), 64'd0);
    axi_writing = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Master busy: the request must wait for axi_wr_ready
    repeat (6) @(negedge clk);
    chk("not ready holds start", 64'(axi_wr_start), 64'd0);
    axi_wr_ready = 1'b1;
    run_burst(1, 29'h3000, 1'b0, "post-reset");

    // Frame start handling with and without bank alternation
    fifo_cnt_1    = '0;
    pingpang      = 1'b1;
    wr_beg_addr_1 = 29'h0;
    wr_end_addr_1 = 29'h1000;
    @(negedge clk);
    wr_load_1 = 1'b1;
    @(negedge clk);
    wr_load_1  = 1'b0;
    fifo_cnt_1 = 10'd16;
    run_burst(1, pp_addr, 1'b0, "pp first load");
    chk("pp wr_bank_1 after first load", 64'(wr_bank_1), 64'd0);
    fifo_cnt_1 = '0;
    wr_load_1  = 1'b1;
    @(negedge clk);
    wr_load_1 = 1'b0;
    @(negedge clk);
    chk("pp wr_bank_1 after second load", 64'(wr_bank_1), 64'(pp_bank));
    fifo_cnt_1 = 10'd16;
    run_burst(1, 29'h0, 1'b0, "pp second load");
    chk("pp wr_bank_2 untouched", 64'(wr_bank_2), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
